// File: rtl/fetch_seq_pkg.sv
// ---------------------------------------------------------------------------
// fetch_seq_pkg : state encodings and defaults shared by the fetch sequencer
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_seq_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_EXEC    = 3'd2;
  localparam logic [2:0] ST_STALLED = 3'd3;
  localparam logic [2:0] ST_HALTED  = 3'd4;

  localparam int TIMEOUT_DEFAULT = 15;

endpackage

`default_nettype wire

// File: rtl/fetch_timeout_cntr.sv
// ---------------------------------------------------------------------------
// fetch_timeout_cntr : clearable, enabled up-counter flagging TIMEOUT-1
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_timeout_cntr
  import fetch_seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // Flag the last waiting cycle so the FSM can still accept an ACK on it
  assign tc_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer : fetch/execute control FSM driving the PC and IMEM handshake
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int RESET_VECTOR = 0,
  parameter int TIMEOUT      = TIMEOUT_DEFAULT,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  halt_i,
  input  logic                  stall_i,
  input  logic                  branch_taken_i,
  input  logic [ADDR_WIDTH-1:0] branch_target_i,
  input  logic [ADDR_WIDTH-1:0] pc_value_i,
  input  logic                  imem_ack_i,
  output logic                  pc_enable_o,
  output logic                  pc_load_o,
  output logic [ADDR_WIDTH-1:0] pc_data_o,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic                  ir_load_o,
  output logic                  running_o,
  output logic                  halted_o,
  output logic                  fault_o,
  output logic [CNT_WIDTH-1:0]  retired_o
);

  state_t               state_q, state_d;
  logic                 fault_q, fault_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 tmo_clr, tmo_en, tmo_tc;
  logic                 retire;

  fetch_timeout_cntr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (tmo_clr),
    .en_i  (tmo_en),
    .tc_o  (tmo_tc)
  );

  always_comb begin
    state_d     = state_q;
    fault_d     = fault_q;
    retired_d   = retired_q;
    pc_enable_o = 1'b0;
    pc_load_o   = 1'b0;
    pc_data_o   = '0;
    imem_req_o  = 1'b0;
    imem_addr_o = '0;
    ir_load_o   = 1'b0;
    tmo_clr     = 1'b1;
    tmo_en      = 1'b0;
    retire      = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALTED: begin
        // START is masked by reset so the outputs stay quiet while held in reset
        if (start_i && rst_n) begin
          pc_enable_o = 1'b1;
          pc_load_o   = 1'b1;
          pc_data_o   = ADDR_WIDTH'(RESET_VECTOR);
          fault_d     = 1'b0;
          state_d     = ST_FETCH;
          if (state_q == ST_IDLE)
            retired_d = '0;
        end
      end
      ST_FETCH: begin
        imem_req_o  = 1'b1;
        imem_addr_o = pc_value_i;
        if (imem_ack_i) begin
          ir_load_o = 1'b1;
          state_d   = ST_EXEC;
        end else if (tmo_tc) begin
          fault_d = 1'b1;
          state_d = ST_HALTED;
        end else begin
          tmo_clr = 1'b0;
          tmo_en  = 1'b1;
        end
      end
      ST_EXEC, ST_STALLED: begin
        if (halt_i) begin
          retire  = 1'b1;
          state_d = ST_HALTED;
        end else if (branch_taken_i) begin
          pc_enable_o = 1'b1;
          pc_load_o   = 1'b1;
          pc_data_o   = branch_target_i;
          retire      = 1'b1;
          state_d     = ST_FETCH;
        end else if (stall_i) begin
          state_d = ST_STALLED;
        end else begin
          pc_enable_o = 1'b1;
          retire      = 1'b1;
          state_d     = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (retire && (retired_q != '1))
      retired_d = retired_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
    end
  end

  assign running_o = (state_q == ST_FETCH) || (state_q == ST_EXEC) || (state_q == ST_STALLED);
  assign halted_o  = (state_q == ST_HALTED);
  assign fault_o   = fault_q;
  assign retired_o = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer : scenario bench with a fetch-address scoreboard
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_sequencer;

  localparam int AW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, halt, stall, branch, ack;
  logic [AW-1:0] target;
  logic [AW-1:0] pc;
  logic          pc_en, pc_ld, req, ir_ld, running, halted, fault;
  logic [AW-1:0] pc_data, addr;
  logic [CW-1:0] retired;

  int compared   = 0;
  int mismatched = 0;
  logic [AW-1:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDR_WIDTH   (AW),
    .RESET_VECTOR (3),
    .TIMEOUT      (15),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start),
    .halt_i          (halt),
    .stall_i         (stall),
    .branch_taken_i  (branch),
    .branch_target_i (target),
    .pc_value_i      (pc),
    .imem_ack_i      (ack),
    .pc_enable_o     (pc_en),
    .pc_load_o       (pc_ld),
    .pc_data_o       (pc_data),
    .imem_req_o      (req),
    .imem_addr_o     (addr),
    .ir_load_o       (ir_ld),
    .running_o       (running),
    .halted_o        (halted),
    .fault_o         (fault),
    .retired_o       (retired)
  );

  // Program counter the sequencer controls
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc <= '0;
    else if (pc_en)
      pc <= pc_ld ? pc_data : pc + 5'd1;
  end

  // Scoreboard: every accepted fetch must match the next expected address
  always @(negedge clk) begin
    if (rst_n && req && ack) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL fetch_addr: unexpected fetch at addr %0d", addr);
      end else begin
        logic [AW-1:0] e;
        e = exp_q.pop_front();
        if (addr !== e) begin
          mismatched++;
          $display("FAIL fetch_addr: got %0d expected %0d", addr, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      #1;
      if (req === 1'b1) seen = 1'b1;
      else tick();
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("FAIL wait_req: imem_req never rose within 40 cycles");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; halt = 1'b0; stall = 1'b0;
    branch = 1'b0; ack = 1'b0; target = '0;
    #3;
    compared++;
    if ({pc_en, pc_ld, req, ir_ld, running, halted, fault} !== 7'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {pc_en, pc_ld, req, ir_ld, running, halted, fault});
    end
    compared++;
    if (retired !== 16'd0 || pc_data !== 5'd0 || addr !== 5'd0) begin
      mismatched++;
      $display("FAIL reset_data: retired=%0d pc_data=%0d addr=%0d expected 0", retired, pc_data, addr);
    end
    start = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    tick();
    start = 1'b1;
    #1;
    compared++;
    if ({pc_en, pc_ld, pc_data} !== {1'b1, 1'b1, 5'd3}) begin
      mismatched++;
      $display("FAIL start_load: got en=%b ld=%b data=%0d expected 1 1 3", pc_en, pc_ld, pc_data);
    end
    exp_q.push_back(5'd3); exp_q.push_back(5'd4); exp_q.push_back(5'd5);
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_req();
      tick(); ack = 1'b1; #1;
      compared++;
      if (ir_ld !== 1'b1) begin
        mismatched++;
        $display("FAIL ir_load[%0d]: got %b expected 1", k, ir_ld);
      end
      tick(); ack = 1'b0; #1;
      compared++;
      if ({pc_en, pc_ld, pc_data} !== {1'b1, 1'b0, 5'd0}) begin
        mismatched++;
        $display("FAIL seq_incr[%0d]: got en=%b ld=%b data=%0d expected 1 0 0", k, pc_en, pc_ld, pc_data);
      end
      tick();
    end
    #1;
    compared++;
    if (retired !== 16'd3 || running !== 1'b1) begin
      mismatched++;
      $display("FAIL retired_seq: got retired=%0d running=%b expected 3 1", retired, running);
    end
  endtask

  task automatic test_branch();
    exp_q.push_back(5'd6); exp_q.push_back(5'd20);
    wait_req();
    tick(); ack = 1'b1;
    tick(); ack = 1'b0; branch = 1'b1; target = 5'd20; #1;
    compared++;
    if ({pc_en, pc_ld} !== 2'b11 || pc_data !== 5'd20) begin
      mismatched++;
      $display("FAIL branch_load: got en=%b ld=%b data=%0d expected 1 1 20", pc_en, pc_ld, pc_data);
    end
    tick(); branch = 1'b0; target = '0;
    wait_req();
    tick(); ack = 1'b1;
    tick(); ack = 1'b0; #1;
    compared++;
    if (retired !== 16'd4) begin
      mismatched++;
      $display("FAIL retired_branch: got %0d expected 4", retired);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1; #1;
    compared++;
    if (pc_en !== 1'b0) begin
      mismatched++;
      $display("FAIL stall_exec: got pc_en=%b expected 0", pc_en);
    end
    for (int i = 0; i < 4; i++) begin
      tick(); stall = (i < 3); #1;
      compared++;
      if ({pc_en, pc_ld, running, halted} !== {(i == 3), 1'b0, 1'b1, 1'b0}) begin
        mismatched++;
        $display("FAIL stalled[%0d]: got en=%b ld=%b run=%b halt=%b expected en=%b 0 1 0",
                 i, pc_en, pc_ld, running, halted, (i == 3));
      end
    end
    exp_q.push_back(5'd21);
    tick(); stall = 1'b0; #1;
    compared++;
    if (retired !== 16'd5) begin
      mismatched++;
      $display("FAIL retired_stall: got %0d expected 5", retired);
    end
  endtask

  task automatic test_halt_branch();
    wait_req();
    tick(); ack = 1'b1;
    tick(); ack = 1'b0; halt = 1'b1; branch = 1'b1; target = 5'd9; #1;
    compared++;
    if ({pc_en, pc_ld, pc_data} !== 7'd0) begin
      mismatched++;
      $display("FAIL halt_prio: got en=%b ld=%b data=%0d expected 0 0 0", pc_en, pc_ld, pc_data);
    end
    tick(); halt = 1'b0; branch = 1'b0; target = '0; #1;
    compared++;
    if ({halted, running} !== 2'b10 || retired !== 16'd6) begin
      mismatched++;
      $display("FAIL halted_state: got halted=%b running=%b retired=%0d expected 1 0 6", halted, running, retired);
    end
    start = 1'b1; #1;
    compared++;
    if ({pc_en, pc_ld, pc_data} !== {1'b1, 1'b1, 5'd3}) begin
      mismatched++;
      $display("FAIL restart_load: got en=%b ld=%b data=%0d expected 1 1 3", pc_en, pc_ld, pc_data);
    end
    tick(); start = 1'b0; #1;
    compared++;
    if (retired !== 16'd6 || running !== 1'b1) begin
      mismatched++;
      $display("FAIL retired_kept: got retired=%0d running=%b expected 6 1", retired, running);
    end
  endtask

  task automatic test_timeout();
    repeat (14) tick();
    #1;
    compared++;
    if ({req, halted, fault} !== 3'b100) begin
      mismatched++;
      $display("FAIL tmo_last_wait: got req=%b halted=%b fault=%b expected 1 0 0", req, halted, fault);
    end
    tick(); #1;
    compared++;
    if ({req, halted, fault} !== 3'b011) begin
      mismatched++;
      $display("FAIL tmo_fault: got req=%b halted=%b fault=%b expected 0 1 1", req, halted, fault);
    end
    start = 1'b1; #1;
    tick(); start = 1'b0; #1;
    compared++;
    if (fault !== 1'b0) begin
      mismatched++;
      $display("FAIL fault_clear: got %b expected 0", fault);
    end
    exp_q.push_back(5'd3);
    repeat (13) tick();
    tick(); ack = 1'b1; #1;
    compared++;
    if ({ir_ld, fault} !== 2'b10) begin
      mismatched++;
      $display("FAIL ack_expiry: got ir_ld=%b fault=%b expected 1 0", ir_ld, fault);
    end
    tick(); ack = 1'b0; #1;
    compared++;
    if ({halted, fault, pc_en} !== 3'b001) begin
      mismatched++;
      $display("FAIL exec_after_expiry: got halted=%b fault=%b en=%b expected 0 0 1", halted, fault, pc_en);
    end
    tick();
  endtask

  task automatic test_reset_wrap();
    #1;
    compared++;
    if (req !== 1'b1 || retired !== 16'd7) begin
      mismatched++;
      $display("FAIL pre_reset: got req=%b retired=%0d expected 1 7", req, retired);
    end
    rst_n = 1'b0; #1;
    compared++;
    if ({req, running, pc_en} !== 3'b000 || retired !== 16'd0) begin
      mismatched++;
      $display("FAIL async_reset: got req=%b run=%b en=%b retired=%0d expected 0 0 0 0", req, running, pc_en, retired);
    end
    tick(); rst_n = 1'b1;
    start = 1'b1; exp_q.push_back(5'd3);
    tick(); start = 1'b0;
    wait_req();
    tick(); ack = 1'b1;
    tick(); ack = 1'b0; branch = 1'b1; target = 5'd31;
    tick(); branch = 1'b0; target = '0; exp_q.push_back(5'd31);
    start = 1'b1; #1;
    compared++;
    if ({pc_en, pc_ld} !== 2'b00) begin
      mismatched++;
      $display("FAIL start_ignored: got en=%b ld=%b expected 0 0", pc_en, pc_ld);
    end
    start = 1'b0;
    wait_req();
    tick(); ack = 1'b1;
    tick(); ack = 1'b0; #1;
    compared++;
    if ({pc_en, pc_ld, pc_data} !== {1'b1, 1'b0, 5'd0}) begin
      mismatched++;
      $display("FAIL wrap_incr: got en=%b ld=%b data=%0d expected 1 0 0", pc_en, pc_ld, pc_data);
    end
    exp_q.push_back(5'd0);
    tick();
    wait_req();
    tick(); ack = 1'b1;
    tick(); ack = 1'b0; #1;
    compared++;
    if (retired !== 16'd2) begin
      mismatched++;
      $display("FAIL retired_after_reset: got %0d expected 2", retired);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_halt_branch();
    test_timeout();
    test_reset_wrap();
    tick();
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d fetches outstanding, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Control FSM that sequences the processor's program counter through fetch/execute cycles.
- Drives the counter's ENABLE/LOAD/DATA inputs and handshakes with instruction memory.
- Applies halt, branch and stall requests from decode/hazard logic in fixed priority.
- Sits between the program counter instance, instruction memory and the instruction register.

Parameters:
ADDR_WIDTH, 5, width of PC, branch target and memory address
RESET_VECTOR, 0, PC value loaded on START
TIMEOUT, 15, max cycles FETCH waits for IMEM_ACK before faulting (>=1)
CNT_WIDTH, 16, width of retired-instruction counter

Ports:
CLOCK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-low reset
START  input  1  begin execution from RESET_VECTOR (honoured in IDLE/HALTED only)
HALT  input  1  halt instruction decoded, sampled in EXEC/STALLED
STALL  input  1  pipeline hazard stall, sampled in EXEC/STALLED
BRANCH_TAKEN  input  1  taken branch/jump, sampled in EXEC/STALLED
BRANCH_TARGET  input  ADDR_WIDTH  branch destination
PC_VALUE  input  ADDR_WIDTH  current program counter value
IMEM_ACK  input  1  instruction memory data valid
PC_ENABLE  output  1  program counter enable
PC_LOAD  output  1  program counter parallel-load select
PC_DATA  output  ADDR_WIDTH  program counter load value
IMEM_REQ  output  1  instruction fetch request
IMEM_ADDR  output  ADDR_WIDTH  fetch address (= PC_VALUE while IMEM_REQ)
IR_LOAD  output  1  latch fetched instruction into IR
RUNNING  output  1  high in FETCH/EXEC/STALLED
HALTED  output  1  high in HALTED
FAULT  output  1  sticky fetch-timeout flag
RETIRED  output  CNT_WIDTH  retired-instruction count

Behaviour:
- States: IDLE, FETCH, EXEC, STALLED, HALTED. Reset -> IDLE, FAULT=0, RETIRED=0, timeout counter=0.
- Outputs during reset and in IDLE without START: all 0.
- Control outputs are combinational from state and inputs. State and counters are registered.
- IDLE/HALTED + START:
  - Drive PC_ENABLE=1, PC_LOAD=1, PC_DATA=RESET_VECTOR.
  - Go to FETCH. FAULT clears.
  - RETIRED clears from IDLE only; it is kept from HALTED.
- FETCH:
  - IMEM_REQ=1, IMEM_ADDR=PC_VALUE. Timeout counter increments each cycle without ACK.
  - IMEM_ACK -> IR_LOAD=1 that cycle, counter cleared, go to EXEC.
  - Counter reaching TIMEOUT without ACK -> FAULT=1, go to HALTED.
  - ACK on the expiry cycle wins.
- EXEC and STALLED evaluate one cycle each, priority HALT > BRANCH_TAKEN > STALL > sequential:
  - HALT: no PC update, RETIRED+1, go to HALTED.
  - BRANCH_TAKEN: PC_ENABLE=1, PC_LOAD=1, PC_DATA=BRANCH_TARGET, RETIRED+1, go to FETCH.
  - STALL: no PC update, go to/stay in STALLED.
  - Otherwise: PC_ENABLE=1, PC_LOAD=0 (increment), RETIRED+1, go to FETCH.
- PC_DATA=0 whenever PC_LOAD=0.
- PC increment wrap (all-ones -> 0) is counter behaviour; no special handling here.
- RETIRED saturates at all-ones.
- START in FETCH/EXEC/STALLED is ignored.
- Branch and halt in the same cycle: halt wins, no PC load.
- Reset mid-operation: IMEM_REQ and all control outputs drop asynchronously; state returns to IDLE.
- IMEM_ACK outside FETCH is ignored.
- Latency: START -> IMEM_REQ 1 cycle. ACK -> next fetch request 2 cycles (EXEC then FETCH) when unstalled.

Decomposition:
- Package fetch_seq_pkg: state enum (IDLE, FETCH, EXEC, STALLED, HALTED) and default TIMEOUT constant.
- One sub-module, fetch_timeout_cntr: clearable, enabled up-counter with terminal-count flag, parameterised by TIMEOUT.

Test Plan:
- Reset, START with RESET_VECTOR=3, ACK 1 cycle after each REQ -> IMEM_ADDR 3, 4, 5. RETIRED=3 after 3 EXECs.
- EXEC with BRANCH_TAKEN=1, BRANCH_TARGET=20 -> PC_LOAD=1, PC_DATA=20 that cycle. Next IMEM_ADDR=20.
- STALL held 4 cycles in EXEC -> 4 cycles STALLED, no PC_ENABLE. On release, one increment, RETIRED +1 only.
- HALT and BRANCH_TAKEN together -> HALTED=1, PC_ENABLE=0. START then reloads RESET_VECTOR, RETIRED preserved.
- IMEM_ACK withheld with TIMEOUT=15 -> FAULT=1, HALTED after 15 cycles. ACK on the expiry cycle -> no fault, EXEC entered.
- RESET asserted mid-FETCH -> IMEM_REQ=0 immediately, state IDLE, RETIRED=0. PC_VALUE=31 increment wraps to 0.
